// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a 32-bit immediate into I/S/B/U/J instruction
// fields over a base word, behind a one-entry valid/ready output register.
// Optional IMM_ENC_CHECK_EN adds representability checking and an error counter.
module imm_encoder #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_sel,
  input  logic [XLEN-1:0]      imm_val,
  input  logic [XLEN-1:0]      inst_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      inst_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  typedef enum logic [2:0] {
    IMM_I_TYPE = 3'd0,
    IMM_S_TYPE = 3'd1,
    IMM_B_TYPE = 3'd2,
    IMM_U_TYPE = 3'd3,
    IMM_J_TYPE = 3'd4
  } imm_sel_e;

  imm_sel_e        sel;
  logic            accept;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] inst_q, inst_d;

  assign sel      = imm_sel_e'(imm_sel);
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    inst_d = inst_base;
    unique case (sel)
      IMM_I_TYPE: inst_d[31:20] = imm_val[11:0];
      IMM_S_TYPE: begin
        inst_d[31:25] = imm_val[11:5];
        inst_d[11:7]  = imm_val[4:0];
      end
      IMM_B_TYPE: begin
        inst_d[31]    = imm_val[12];
        inst_d[30:25] = imm_val[10:5];
        inst_d[11:8]  = imm_val[4:1];
        inst_d[7]     = imm_val[11];
      end
      IMM_U_TYPE: inst_d[31:12] = imm_val[31:12];
      IMM_J_TYPE: begin
        inst_d[31]    = imm_val[20];
        inst_d[30:21] = imm_val[10:1];
        inst_d[20]    = imm_val[11];
        inst_d[19:12] = imm_val[19:12];
      end
      default: inst_d = inst_base;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      inst_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) inst_q <= inst_d;
    end
  end

  assign out_valid = out_valid_q;
  assign inst_o    = inst_q;

`ifdef IMM_ENC_CHECK_EN
  logic                 err_d, err_q;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

  always_comb begin
    err_d = 1'b1;
    unique case (sel)
      IMM_I_TYPE, IMM_S_TYPE: err_d = ~(&imm_val[31:11] | ~|imm_val[31:11]);
      IMM_B_TYPE: err_d = imm_val[0] | ~(&imm_val[31:12] | ~|imm_val[31:12]);
      IMM_U_TYPE: err_d = |imm_val[11:0];
      IMM_J_TYPE: err_d = imm_val[0] | ~(&imm_val[31:20] | ~|imm_val[31:20]);
      default:    err_d = 1'b1;
    endcase
  end

  // Clear wins over a same-cycle increment; the counter sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)                          err_cnt_d = '0;
    else if (accept & err_d & ~&err_cnt_q) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      if (accept) err_q <= err_d;
    end
  end

  assign err_o   = err_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_ok;

  assign unused_ok = ^{err_clr, imm_val[0]};
  assign err_o     = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule
